pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; one clock, no other clock domains.
REQ-003 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-004 id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-005 ex_mem_read  input  1  instruction in EX is a load.
REQ-006 ex_rd  input  5  destination index of the instruction in EX.
REQ-007 ex_branch_taken  input  1  branch/jump in EX resolved taken this cycle.
REQ-008 mem_busy  input  1  data memory cannot complete the MEM-stage access this cycle.
REQ-009 pc_stall  output  1  hold PC.
REQ-010 if_id_stall  output  1  hold IF/ID register.
REQ-011 if_id_flush  output  1  clear IF/ID register to a bubble.
REQ-012 ID_stall  output  1  load a bubble (all fields zero) into ID/EX; drives the ID/EX register's ID_stall port directly.
REQ-013 id_ex_hold, ex_mem_hold  output  1 each  hold ID/EX and EX/MEM contents.
REQ-014 mem_wb_bubble  output  1  load a bubble into MEM/WB.
REQ-015 stall_cycles  output  16  count of cycles with pc_stall=1.
REQ-016 mem_timeout  output  1  sticky memory-wait watchdog flag.

Function
REQ-017 Hazard outputs (REQ-009..014) SHALL be combinational from inputs, evaluated in strict priority: mem_busy > ex_branch_taken > load-use > none.
REQ-018 mem_busy=1: pc_stall, if_id_stall, id_ex_hold, ex_mem_hold, mem_wb_bubble SHALL be 1; if_id_flush and ID_stall SHALL be 0, even if a branch or load-use is present.
REQ-019 Otherwise, ex_branch_taken=1: if_id_flush=1 and ID_stall=1; all other hazard outputs 0. A load-use in the same cycle is discarded.
REQ-020 Otherwise, load-use SHALL be ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); when true: pc_stall=1, if_id_stall=1, ID_stall=1; others 0.
REQ-021 With no hazard, all hazard outputs SHALL be 0.
REQ-022 FSM states RUN, MEM_WAIT. RUN->MEM_WAIT on an edge with mem_busy=1; MEM_WAIT->RUN on an edge with mem_busy=0; otherwise remain.
REQ-023 wait_cnt (8 bit, internal) SHALL clear on RUN->MEM_WAIT, increment on each edge in MEM_WAIT with mem_busy=1, and saturate at 255.
REQ-024 mem_timeout SHALL set on the edge at which wait_cnt=255 and mem_busy=1; it stays 1 until rst; it does not alter stall behaviour.
REQ-025 stall_cycles SHALL increment on every edge where pc_stall=1 and saturate at 16'hFFFF (no wrap).
REQ-026 ex_rd=0 SHALL never produce a load-use stall.

Reset
REQ-027 rst=1 SHALL asynchronously force state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0.
REQ-028 While rst=1, all hazard outputs SHALL be 0 regardless of inputs.
REQ-029 rst asserted mid-MEM_WAIT SHALL abandon the wait; after release, with mem_busy=1 the FSM re-enters MEM_WAIT and wait_cnt starts from 0.

Verification
REQ-030 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_stall=if_id_stall=ID_stall=1 that cycle; stall_cycles 0->1.
REQ-031 Zero/unused register: ex_rd=0 = id_rs1 with id_use_rs1=1; then ex_rd=7=id_rs1 with id_use_rs1=0 -> no stall in either case.
REQ-032 Branch vs load-use: ex_branch_taken=1 with an active load-use -> if_id_flush=1, ID_stall=1, pc_stall=0; stall_cycles unchanged.
REQ-033 Memory wait: mem_busy=1 for 3 cycles with ex_branch_taken=1 -> freeze outputs for 3 cycles, no flush; FSM returns to RUN; stall_cycles +3; then flush appears once mem_busy=0.
REQ-034 Watchdog: mem_busy=1 held 300 cycles -> mem_timeout rises after 256 MEM_WAIT cycles and stays 1 after mem_busy drops; rst clears it.
REQ-035 Saturation/reset: preload stall_cycles to 16'hFFFE, stall 3 cycles -> holds 16'hFFFF; assert rst mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush/hold decode plus a
// memory-wait FSM with watchdog and a saturating stall-cycle counter.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        ID_stall,
  output logic        id_ex_hold,
  output logic        ex_mem_hold,
  output logic        mem_wb_bubble,
  output logic [15:0] stall_cycles,
  output logic        mem_timeout
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic        mem_timeout_q;
  logic [15:0] stall_cycles_q;
  logic [15:0] stall_cycles_d;
  logic        load_use;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    ID_stall      = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        ID_stall    = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        ID_stall    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (!mem_busy) begin
            state_q <= RUN;
          end else if (wait_cnt_q == 8'hFF) begin
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (pc_stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy;
  logic        pc_stall, if_id_stall, if_id_flush, ID_stall;
  logic        id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_timeout;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state
  bit m_waiting;
  int m_wcnt;
  int m_stall;
  bit m_to;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .ID_stall(ID_stall), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
    .mem_wb_bubble(mem_wb_bubble), .stall_cycles(stall_cycles),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit f_load_use();
    bit hit1, hit2;
    hit1 = id_use_rs1 && (int'(id_rs1) == int'(ex_rd));
    hit2 = id_use_rs2 && (int'(id_rs2) == int'(ex_rd));
    return ex_mem_read && (int'(ex_rd) != 0) && (hit1 || hit2);
  endfunction

  // order: pc_stall, if_id_stall, if_id_flush, ID_stall, id_ex_hold, ex_mem_hold, mem_wb_bubble
  function automatic logic [6:0] f_expect_hz();
    if (rst)             return 7'b0000000;
    if (mem_busy)        return 7'b1100111;
    if (ex_branch_taken) return 7'b0011000;
    if (f_load_use())    return 7'b1101000;
    return 7'b0000000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_waiting = 1'b0;
      m_wcnt    = 0;
      m_stall   = 0;
      m_to      = 1'b0;
    end else begin
      if (f_expect_hz()[6]) m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
      if (!m_waiting) begin
        if (mem_busy) begin
          m_waiting = 1'b1;
          m_wcnt    = 0;
        end
      end else if (!mem_busy) begin
        m_waiting = 1'b0;
      end else begin
        if (m_wcnt == 255) m_to = 1'b1;
        m_wcnt = (m_wcnt + 1 > 255) ? 255 : m_wcnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("hazard_vec", {25'd0, pc_stall, if_id_stall, if_id_flush, ID_stall,
                       id_ex_hold, ex_mem_hold, mem_wb_bubble}, {25'd0, f_expect_hz()});
    chk("stall_cycles", {16'd0, stall_cycles}, m_stall);
    chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
  end

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic mr, input logic [4:0] rd,
                        input logic br, input logic busy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; mem_busy = busy;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    // hazards present while in reset must stay masked
    set_in(0, 5, 0, 1, 1, 5, 1, 1);
    #1;
    chk("reset_masks_hz", {25'd0, pc_stall, if_id_stall, if_id_flush, ID_stall,
                           id_ex_hold, ex_mem_hold, mem_wb_bubble}, 32'd0);
    next();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    // load-use on rs2
    set_in(0, 5, 0, 1, 1, 5, 0, 0);
    @(negedge clk);
    chk("lu_pc_stall", {31'd0, pc_stall}, 32'd1);
    chk("lu_if_id_stall", {31'd0, if_id_stall}, 32'd1);
    chk("lu_ID_stall", {31'd0, ID_stall}, 32'd1);
    chk("lu_cnt_before", {16'd0, stall_cycles}, 32'd0);
    next();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_cnt_after", {16'd0, stall_cycles}, 32'd1);
    next();

    // x0 destination, then unused source
    set_in(0, 0, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("x0_no_stall", {31'd0, pc_stall}, 32'd0);
    next();
    set_in(7, 0, 0, 0, 1, 7, 0, 0);
    @(negedge clk);
    chk("unused_no_stall", {30'd0, pc_stall, ID_stall}, 32'd0);
    next();

    // branch beats load-use
    set_in(0, 5, 0, 1, 1, 5, 1, 0);
    @(negedge clk);
    chk("br_flush", {31'd0, if_id_flush}, 32'd1);
    chk("br_ID_stall", {31'd0, ID_stall}, 32'd1);
    chk("br_pc_stall", {31'd0, pc_stall}, 32'd0);
    next();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("br_cnt_unchanged", {16'd0, stall_cycles}, 32'd1);
    next();

    // memory wait overrides a pending branch for three cycles
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_freeze", {25'd0, pc_stall, if_id_stall, if_id_flush, ID_stall,
                        id_ex_hold, ex_mem_hold, mem_wb_bubble}, 32'b1100111);
      next();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("mw_flush_after", {31'd0, if_id_flush}, 32'd1);
    chk("mw_cnt", {16'd0, stall_cycles}, 32'd4);
    next();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    // watchdog: first busy edge enters the wait, 256 more trip the flag
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 300; i++) begin
      next();
      if (i == 256) chk("wd_not_yet", {31'd0, mem_timeout}, 32'd0);
      if (i == 257) chk("wd_set", {31'd0, mem_timeout}, 32'd1);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    next();
    next();
    chk("wd_sticky", {31'd0, mem_timeout}, 32'd1);
    chk("wd_cnt", {16'd0, stall_cycles}, 32'd304);
    rst = 1'b1;
    #1;
    chk("wd_rst_clear", {31'd0, mem_timeout}, 32'd0);
    next();
    rst = 1'b0;

    // randomized traffic with bursty mem_busy and occasional async reset
    for (int n = 0; n < 2500; n++) begin
      logic b;
      b = ($urandom_range(0, 99) < (mem_busy ? 85 : 10));
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 5) == 0), b);
      rst = ($urandom_range(0, 299) == 0);
      next();
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    // counter saturation, then reset in the middle of the stall
    rst = 1'b1;
    next();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (65534) next();
    chk("sat_fffe", {16'd0, stall_cycles}, 32'h0000FFFE);
    repeat (3) next();
    chk("sat_ffff", {16'd0, stall_cycles}, 32'h0000FFFF);
    chk("sat_still_stall", {31'd0, pc_stall}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midstall_rst_hz", {25'd0, pc_stall, if_id_stall, if_id_flush, ID_stall,
                            id_ex_hold, ex_mem_hold, mem_wb_bubble}, 32'd0);
    chk("midstall_rst_cnt", {16'd0, stall_cycles}, 32'd0);
    chk("midstall_rst_to", {31'd0, mem_timeout}, 32'd0);
    next();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
